// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one registered memory port.
// Data wins by default; a waiting fetch is forced through after MAX_DSTREAK data grants.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam int unsigned SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
    localparam logic [SW-1:0] StreakMax = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          grant_fetch, grant_data;

    // Grants are only ever issued from idle; the streak limit overrides data priority.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == StIdle) begin
            if (if_req && (!d_req || dstreak_q == StreakMax)) begin
                grant_fetch = 1'b1;
            end else if (d_req) begin
                grant_data = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_be_d     = m_be_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_fetch) begin
                    state_d   = StBusyI;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_be_d    = 4'hF;
                    m_addr_d  = if_addr;
                    m_wdata_d = 32'h0;
                end else if (grant_data) begin
                    state_d   = StBusyD;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end
            end
            StBusyI: begin
                if (m_ack) begin
                    state_d    = StResp;
                    m_req_d    = 1'b0;
                    if_rdata_d = m_rdata;
                    if_ack_d   = 1'b1;
                end
            end
            StBusyD: begin
                if (m_ack) begin
                    state_d = StResp;
                    m_req_d = 1'b0;
                    d_ack_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Streak only counts data wins against a fetch that is actually waiting.
    always_comb begin
        dstreak_d = dstreak_q;
        if (!if_req || grant_fetch) begin
            dstreak_d = '0;
        end else if (grant_data && dstreak_q != StreakMax) begin
            dstreak_d = dstreak_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dstreak_q  <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= 4'h0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            dstreak_q  <= dstreak_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_be_q     <= m_be_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DSTREAK, default 4: max consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk  input  1  core clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port if_req  input  1  fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_rdata  output  32  fetched instruction, registered.
REQ-007 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-009 SHALL have port d_we  input  1  data write enable.
REQ-010 SHALL have port d_be  input  4  data byte enables.
REQ-011 SHALL have port d_addr  input  32  data byte address.
REQ-012 SHALL have port d_wdata  input  32  store data.
REQ-013 SHALL have port d_rdata  output  32  load data, registered.
REQ-014 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-015 SHALL have ports m_req/m_we  output  1 each, m_be  output  4, m_addr/m_wdata  output  32 each: shared memory port, all registered.
REQ-016 SHALL have ports m_rdata  input  32 and m_ack  input  1: memory response, valid when m_ack high.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-018 In IDLE with any request, SHALL grant on the clock edge, latch the winner's address/controls into m_* and enter BUSY_I or BUSY_D; m_req high from the next cycle.
REQ-019 Arbitration SHALL favour data over fetch, except grant fetch when if_req is high and dstreak equals MAX_DSTREAK.
REQ-020 dstreak SHALL increment (saturating at MAX_DSTREAK) on each data grant while if_req is high, and clear on any fetch grant or any cycle if_req is low.
REQ-021 Fetch grants SHALL drive m_we=0, m_be=4'hF, m_wdata=0.
REQ-022 m_req and all m_* SHALL stay constant in BUSY_x until m_ack; m_ack is accepted in the same cycle m_req is high (zero-wait memory allowed).
REQ-023 On m_ack in BUSY_x, SHALL register m_rdata into the granted requester's rdata (writes leave d_rdata unchanged), deassert m_req and enter RESP.
REQ-024 In RESP, SHALL pulse the granted requester's ack for exactly one cycle, make no new grant, and return to IDLE.
REQ-025 Minimum request-to-ack latency SHALL be 2 cycles after request: grant edge, m_ack cycle, ack in RESP; back-to-back grants every 3 cycles.
REQ-026 m_ack in IDLE or RESP SHALL be ignored with no state or output change.
REQ-027 A request dropped before its ack SHALL be a protocol violation; the in-flight transaction still completes and acks.
REQ-028 if_rdata/d_rdata SHALL hold their last value until the next completion for that requester.

Reset
REQ-029 While rst_n is low at a clock edge: state IDLE, dstreak 0, m_req 0, m_we 0, m_be 0, m_addr 0, m_wdata 0, if_ack 0, d_ack 0, if_rdata 0, d_rdata 0.
REQ-030 Reset during BUSY_x or RESP SHALL abandon the transaction with no ack; a later m_ack for it SHALL be ignored.

Verification
REQ-031 Fetch only, if_addr=0x100, m_ack same cycle as m_req with m_rdata=0x00500093 -> m_req one cycle, if_ack at cycle 2, if_rdata=0x00500093.
REQ-032 if_req and d_req together, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'hF -> data granted first, m_we=1, d_ack, then fetch granted with m_we=0, m_be=4'hF.
REQ-033 d_req held high continuously with if_req pending, MAX_DSTREAK=4 -> exactly 4 data grants, then one fetch grant, then dstreak 0.
REQ-034 Memory ack delayed 5 cycles -> m_addr/m_we/m_wdata stable all 5 cycles, single ack pulse, no second grant during RESP.
REQ-035 rst_n low for 1 cycle in BUSY_D -> all outputs at reset values next cycle, no d_ack, stray m_ack afterwards ignored.
REQ-036 Spurious m_ack in IDLE with no requests -> no ack, rdata outputs unchanged.
